// File: rtl/pool_kxk_stream.sv
// pool_kxk_stream: streaming KxK (2x2/3x3) average/max pooling over raster-ordered,
// multi-plane frames. Fixed 3-cycle latency from the window-completing pixel.
// Optional build macro POOL_ROUND_EN: average mode rounds half away from zero
// instead of truncating toward zero.
module pool_kxk_stream #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned IMAGE_WIDTH  = 16,
   parameter int unsigned IMAGE_HEIGHT = 16,
   parameter int unsigned KERNEL       = 3,
   parameter int unsigned STRIDE       = 1,
   parameter int unsigned CHANNEL_NUM  = 512,
   parameter int unsigned MODE_MAX     = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   input  logic signed [DATA_WIDTH-1:0] pxl_in,
   output logic signed [DATA_WIDTH-1:0] pxl_out,
   output logic                         valid_out,
   output logic                         frame_done
);

   localparam int unsigned COL_W    = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int unsigned ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int unsigned PLN_W    = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;
   localparam int unsigned SUM_W    = DATA_WIDTH + 4;
   localparam int unsigned KK       = KERNEL * KERNEL;
   localparam int unsigned LAST_COL = (KERNEL - 1) + ((IMAGE_WIDTH  - KERNEL) / STRIDE) * STRIDE;
   localparam int unsigned LAST_ROW = (KERNEL - 1) + ((IMAGE_HEIGHT - KERNEL) / STRIDE) * STRIDE;
   localparam logic signed [SUM_W-1:0] KK_S   = SUM_W'(KK);
   localparam logic signed [SUM_W-1:0] HALF_S = SUM_W'(KK / 2);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [PLN_W-1:0] plane;
   logic             col_ph;
   logic             row_ph;

   logic col_last_c;
   logic row_last_c;
   logic plane_last_c;
   logic win_done_c;
   logic last_win_c;

   // Raster position decode; phase bits stand in for the stride modulo terms
   assign col_last_c   = (col   == COL_W'(IMAGE_WIDTH - 1));
   assign row_last_c   = (row   == ROW_W'(IMAGE_HEIGHT - 1));
   assign plane_last_c = (plane == PLN_W'(CHANNEL_NUM - 1));
   assign win_done_c   = (row >= ROW_W'(KERNEL - 1)) && (col >= COL_W'(KERNEL - 1)) &&
                         !col_ph && !row_ph;
   assign last_win_c   = win_done_c && plane_last_c &&
                         (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

   // Column/row/plane counters and stride phases, advancing only on accepted pixels
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col    <= '0;
         row    <= '0;
         plane  <= '0;
         col_ph <= 1'b0;
         row_ph <= 1'b0;
      end else if (valid_in) begin
         if (col_last_c) begin
            col    <= '0;
            col_ph <= 1'b0;
            if (row_last_c) begin
               row    <= '0;
               row_ph <= 1'b0;
               plane  <= plane_last_c ? '0 : plane + PLN_W'(1);
            end else begin
               row    <= row + ROW_W'(1);
               row_ph <= ((STRIDE == 2) && (row >= ROW_W'(KERNEL - 1))) ? ~row_ph : 1'b0;
            end
         end else begin
            col    <= col + COL_W'(1);
            col_ph <= ((STRIDE == 2) && (col >= COL_W'(KERNEL - 1))) ? ~col_ph : 1'b0;
         end
      end
   end

   // Line buffers: g_lb[0] holds the previous row, g_lb[k] the row k+1 above
   for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
      logic signed [DATA_WIDTH-1:0] mem [IMAGE_WIDTH];
      if (k == 0) begin : g_first
         // Newest row is written from the incoming pixel
         always_ff @(posedge clk) begin
            if (valid_in) mem[col] <= pxl_in;
         end
      end else begin : g_chain
         // Older rows cascade from the buffer one row newer
         always_ff @(posedge clk) begin
            if (valid_in) mem[col] <= g_lb[k-1].mem[col];
         end
      end
   end

   logic s0_vld;
   logic s0_win;
   logic s0_last;

   // Stage 0 flags: pixel accepted, window completes, last window of frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_vld  <= 1'b0;
         s0_win  <= 1'b0;
         s0_last <= 1'b0;
      end else begin
         s0_vld  <= valid_in;
         s0_win  <= valid_in && win_done_c;
         s0_last <= valid_in && last_win_c;
      end
   end

   // Stage 0 column capture: row r of the incoming column, r = KERNEL-1 is newest
   for (genvar r = 0; r < KERNEL; r++) begin : g_colq
      logic signed [DATA_WIDTH-1:0] q;
      if (r == KERNEL - 1) begin : g_new
         // Current pixel enters the newest row slot
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)        q <= '0;
            else if (valid_in) q <= pxl_in;
         end
      end else begin : g_old
         // Older rows come from the matching line buffer at this column
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)        q <= '0;
            else if (valid_in) q <= g_lb[KERNEL-2-r].mem[col];
         end
      end
   end

   logic signed [DATA_WIDTH-1:0] win_vec [KK];

   // Window shift register, flat index r*KERNEL+c, column KERNEL-1 is newest
   for (genvar i = 0; i < KK; i++) begin : g_win
      logic signed [DATA_WIDTH-1:0] q;
      assign win_vec[i] = q;
      if ((i % KERNEL) == KERNEL - 1) begin : g_load
         // Newest column loads from the captured column
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)      q <= '0;
            else if (s0_vld) q <= g_colq[i / KERNEL].q;
         end
      end else begin : g_shift
         // Older columns shift left one position per accepted pixel
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)      q <= '0;
            else if (s0_vld) q <= g_win[i+1].q;
         end
      end
   end

   logic s1_win;
   logic s1_last;

   // Stage 1 flags track the window registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_win  <= 1'b0;
         s1_last <= 1'b0;
      end else begin
         s1_win  <= s0_win;
         s1_last <= s0_last;
      end
   end

   logic signed [SUM_W-1:0]      sum_chain [KK+1];
   logic signed [DATA_WIDTH-1:0] max_chain [KK];
   logic signed [SUM_W-1:0]      red_c;

   assign sum_chain[0] = '0;
   assign max_chain[0] = win_vec[0];
   // Sign-extended accumulation and signed running maximum over the window
   for (genvar i = 0; i < KK; i++) begin : g_red
      assign sum_chain[i+1] = sum_chain[i] + SUM_W'(win_vec[i]);
      if (i > 0) begin : g_max
         assign max_chain[i] = (win_vec[i] > max_chain[i-1]) ? win_vec[i] : max_chain[i-1];
      end
   end
   assign red_c = (MODE_MAX != 0) ? SUM_W'(max_chain[KK-1]) : sum_chain[KK];

   logic signed [SUM_W-1:0] red_q;
   logic                    s2_win;
   logic                    s2_last;

   // Stage 2: reduction register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         red_q   <= '0;
         s2_win  <= 1'b0;
         s2_last <= 1'b0;
      end else begin
         if (s1_win) red_q <= red_c;
         s2_win  <= s1_win;
         s2_last <= s1_last;
      end
   end

   logic signed [SUM_W-1:0]      adj_c;
   logic signed [SUM_W-1:0]      quot_c;
   logic signed [DATA_WIDTH-1:0] res_c;

`ifdef POOL_ROUND_EN
   // Bias by half the divisor away from zero before the truncating divide
   always_comb begin
      adj_c = red_q[SUM_W-1] ? (red_q - HALF_S) : (red_q + HALF_S);
   end
`else
   // Plain truncating average
   always_comb begin
      adj_c = red_q;
   end
`endif

   assign quot_c = adj_c / KK_S;
   assign res_c  = (MODE_MAX != 0) ? DATA_WIDTH'(red_q) : DATA_WIDTH'(quot_c);

   // Stage 3: output register; pxl_out holds between valid pixels
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out    <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (s2_win) pxl_out <= res_c;
         valid_out  <= s2_win;
         frame_done <= s2_last;
      end
   end

endmodule

// File: tb/tb_pool_kxk_stream.sv
// Directed testbench for pool_kxk_stream: three instances on a shared input stream
// (3x3 avg single plane, 2x2 stride-2 max, 3x3 avg three planes).
module tb_pool_kxk_stream;

   typedef struct {
      int v;
      int e;
      bit fd;
   } rec_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               valid_in;
   logic signed [15:0] pxl_in;

   logic signed [15:0] pa, pb, pc;
   logic               va, vb, vc;
   logic               fa, fb, fc;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int pix_edge [64];
   rec_t qa[$], qb[$], qc[$];
   int fda = 0, fdb = 0, fdc = 0;

   pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNEL(3),
                     .STRIDE(1), .CHANNEL_NUM(1), .MODE_MAX(0)) u_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out(pa), .valid_out(va), .frame_done(fa));

   pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNEL(2),
                     .STRIDE(2), .CHANNEL_NUM(1), .MODE_MAX(1)) u_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out(pb), .valid_out(vb), .frame_done(fb));

   pool_kxk_stream #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNEL(3),
                     .STRIDE(1), .CHANNEL_NUM(3), .MODE_MAX(0)) u_c (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
      .pxl_out(pc), .valid_out(vc), .frame_done(fc));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output capture on the falling edge, stamped with the rising edge that produced it
   always @(negedge clk) begin
      if (va) qa.push_back(rec_t'{int'(pa), cyc - 1, fa});
      if (vb) qb.push_back(rec_t'{int'(pb), cyc - 1, fb});
      if (vc) qc.push_back(rec_t'{int'(pc), cyc - 1, fc});
      if (fa) fda++;
      if (fb) fdb++;
      if (fc) fdc++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int which);
      case (which)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic rec_t get_rec(input int which, input int idx);
      case (which)
         0:       return qa[idx];
         1:       return qb[idx];
         default: return qc[idx];
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
         pxl_in   = 16'h7abc;
      end
   endtask

   // kind 0: ramp row*8+col, kind 1: constant cval, kind 2: -14 at (0,0) else 0
   task automatic send_plane(input int kind, input int cval, input int gap, input int npix);
      int v;
      for (int i = 0; i < npix; i++) begin
         case (kind)
            0:       v = i;
            1:       v = cval;
            default: v = (i == 0) ? -14 : 0;
         endcase
         @(negedge clk);
         valid_in = 1'b1;
         pxl_in   = 16'(v);
         @(posedge clk);
         pix_edge[i] = cyc;
         if (gap > 0) idle(gap);
      end
   endtask

   // 3x3 stride-1 average of the 8x8 ramp: each output equals the window centre
   task automatic check_ramp3(input string tag, input int which, input int base, input int fd_last);
      rec_t r;
      chk({tag, "_cnt"}, qsize(which) - base, 36);
      if (qsize(which) - base >= 36) begin
         for (int k = 0; k < 36; k++) begin
            r = get_rec(which, base + k);
            chk($sformatf("%s_val%0d", tag, k), r.v, (k / 6 + 1) * 8 + (k % 6) + 1);
            chk($sformatf("%s_lat%0d", tag, k), r.e - pix_edge[(k / 6 + 2) * 8 + (k % 6) + 2], 3);
            chk($sformatf("%s_fd%0d", tag, k), int'(r.fd), (k == 35) ? fd_last : 0);
         end
      end
   endtask

   // 2x2 stride-2 max of the 8x8 ramp: each output equals the bottom-right pixel
   task automatic check_ramp_b(input string tag, input int base);
      rec_t r;
      chk({tag, "_cnt"}, qb.size() - base, 16);
      if (qb.size() - base >= 16) begin
         for (int k = 0; k < 16; k++) begin
            r = qb[base + k];
            chk($sformatf("%s_val%0d", tag, k), r.v, (2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1);
            chk($sformatf("%s_lat%0d", tag, k), r.e - pix_edge[(2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1], 3);
            chk($sformatf("%s_fd%0d", tag, k), int'(r.fd), (k == 15) ? 1 : 0);
         end
      end
   endtask

   initial begin
      int na, nb, nc, f0a, f0b, f0c, exp_round;
      rec_t r;
      reset    = 1'b0;
      valid_in = 1'b0;
      pxl_in   = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_va", int'(va), 0);  chk("rst_pa", int'(pa), 0);  chk("rst_fa", int'(fa), 0);
      chk("rst_vb", int'(vb), 0);  chk("rst_pb", int'(pb), 0);  chk("rst_fb", int'(fb), 0);
      chk("rst_vc", int'(vc), 0);  chk("rst_pc", int'(pc), 0);  chk("rst_fc", int'(fc), 0);
      reset = 1'b1;
      idle(2);

      // Ramp, continuous valid
      na = qa.size(); nb = qb.size(); f0a = fda; f0b = fdb;
      send_plane(0, 0, 0, 64);
      idle(6);
      check_ramp3("t1a", 0, na, 1);
      chk("t1a_fdcnt", fda - f0a, 1);
      check_ramp_b("t2b", nb);
      chk("t2b_fdcnt", fdb - f0b, 1);

      // Constant -5 frame followed back-to-back by a lone -14 frame
`ifdef POOL_ROUND_EN
      exp_round = -2;
`else
      exp_round = -1;
`endif
      na = qa.size(); nb = qb.size(); f0a = fda;
      send_plane(1, -5, 0, 64);
      send_plane(2, 0, 0, 64);
      idle(6);
      chk("t3a_cnt", qa.size() - na, 72);
      chk("t3a_fdcnt", fda - f0a, 2);
      if (qa.size() - na >= 72) begin
         for (int k = 0; k < 36; k++) chk($sformatf("t3a_neg5_%0d", k), qa[na + k].v, -5);
         chk("t3a_fd_first", int'(qa[na + 35].fd), 1);
         r = qa[na + 36];
         chk("t3a_single_val", r.v, exp_round);
         chk("t3a_single_lat", r.e - pix_edge[18], 3);
         chk("t3a_zero_val", qa[na + 37].v, 0);
         chk("t3a_last_val", qa[na + 71].v, 0);
         chk("t3a_fd_second", int'(qa[na + 71].fd), 1);
      end
      chk("t3b_cnt", qb.size() - nb, 32);
      if (qb.size() - nb >= 32) begin
         chk("t3b_neg5_first", qb[nb].v, -5);
         chk("t3b_neg5_last", qb[nb + 15].v, -5);
         chk("t3b_single_max", qb[nb + 16].v, 0);
      end

      // Ramp with valid_in pattern 1,0,0
      na = qa.size(); nb = qb.size();
      send_plane(0, 0, 2, 64);
      idle(6);
      check_ramp3("t4a", 0, na, 1);
      check_ramp_b("t4b", nb);

      // Three-plane frame, constant p*10 per plane
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      @(negedge clk); reset = 1'b1;
      idle(2);
      nc = qc.size(); f0c = fdc;
      for (int p = 0; p < 3; p++) send_plane(1, p * 10, 0, 64);
      idle(6);
      chk("t5c_cnt", qc.size() - nc, 108);
      chk("t5c_fdcnt", fdc - f0c, 1);
      if (qc.size() - nc >= 108) begin
         for (int k = 0; k < 108; k++) begin
            chk($sformatf("t5c_val%0d", k), qc[nc + k].v, (k / 36) * 10);
            chk($sformatf("t5c_fd%0d", k), int'(qc[nc + k].fd), (k == 107) ? 1 : 0);
         end
      end

      // Reset in the middle of plane 1
      send_plane(1, 0, 0, 64);
      send_plane(1, 7, 0, 30);
      @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b0;
      #1;
      nc = qc.size(); f0c = fdc;
      chk("t6_rst_vc0", int'(vc), 0);
      chk("t6_rst_pc0", int'(pc), 0);
      @(negedge clk);
      #1;
      chk("t6_rst_vc1", int'(vc), 0);
      chk("t6_rst_fc1", int'(fc), 0);
      @(negedge clk); reset = 1'b1;
      idle(5);
      chk("t6_quiet", qc.size() - nc, 0);
      send_plane(0, 0, 0, 64);
      idle(6);
      check_ramp3("t6c", 2, nc, 0);
      chk("t6c_fdcnt", fdc - f0c, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pool_kxk_stream.md
Name: pool_kxk_stream

Overview:
- Parametrised streaming pooling engine; successor to the fixed 3x3 average-pool stage.
- Supports 2x2/3x3 kernels, stride 1/2, average or max mode, and multi-plane frames.
- Accepts one raster-ordered pixel per valid, plane after plane; emits pooled pixels in raster order with no padding.
- Sits between the loop-data reader and the next conv/concat stage, in place of per-size avg-pool wrappers.

Parameters:
DATA_WIDTH, 16, signed two's-complement pixel width
IMAGE_WIDTH, 16, input columns per plane (>= KERNEL)
IMAGE_HEIGHT, 16, input rows per plane (>= KERNEL)
KERNEL, 3, window size; legal values 2 or 3
STRIDE, 1, window step in both axes; legal values 1 or 2
CHANNEL_NUM, 512, planes per frame
MODE_MAX, 0, 0 = average pooling, 1 = max pooling

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
valid_in  input  1  pxl_in valid this cycle
pxl_in  input  DATA_WIDTH  input pixel, signed
pxl_out  output  DATA_WIDTH  pooled pixel, signed
valid_out  output  1  pxl_out valid, single-cycle per pixel
frame_done  output  1  one-cycle pulse with the last valid_out of plane CHANNEL_NUM-1

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While asserted, pxl_out=0, valid_out=0, frame_done=0, and all counters, window registers and pipeline valids are 0. Line buffer contents are don't-care. A reset mid-frame discards the partial frame; the first valid_in after release is row 0, col 0, plane 0.
- No backpressure: every valid_in pixel is consumed. Gaps in valid_in are allowed. Counters and shift registers advance only on valid_in=1.
- Counters: col (0..IMAGE_WIDTH-1), row (0..IMAGE_HEIGHT-1), plane (0..CHANNEL_NUM-1).
  - col wraps to 0 and increments row.
  - row wraps and increments plane.
  - plane wraps to 0 after CHANNEL_NUM-1.
- Line storage: KERNEL-1 line buffers of IMAGE_WIDTH entries plus a KERNEL x KERNEL window shift register. Windows never straddle rows or planes; output eligibility is gated by the counters.
- Window complete when the current pixel has all of: row >= KERNEL-1, col >= KERNEL-1, (row-KERNEL+1) mod STRIDE == 0, (col-KERNEL+1) mod STRIDE == 0. The modulo terms use phase counters, not dividers.
- Output count per plane: ((IMAGE_WIDTH-KERNEL)/STRIDE+1) x ((IMAGE_HEIGHT-KERNEL)/STRIDE+1).
- Pipeline: the window-completing pixel is sampled at edge N. Window registers update at N+1. Reduction registers at N+2. pxl_out/valid_out update at N+3. Fixed latency 3; no bubbles inserted.
- Average: sum width DATA_WIDTH+4, signed. Result = sum / (KERNEL*KERNEL) with truncation toward zero (signed constant divide). The result always fits DATA_WIDTH, so no saturation.
- Max: signed compare tree; ties are irrelevant.
- valid_out is low on cycles without a completed window. pxl_out holds its last value while valid_out is low.
- frame_done asserts with valid_out on the final window of plane CHANNEL_NUM-1, then deasserts next cycle.
- Back-to-back frames: plane 0 of the next frame may start the cycle after the last pixel. No dead cycle is required.

Optional Feature:
- POOL_ROUND_EN defined: average mode rounds half away from zero, i.e. (sum + sign(sum)*floor(KERNEL*KERNEL/2)) / (KERNEL*KERNEL).
- POOL_ROUND_EN undefined: plain truncation toward zero.
- Max mode is unaffected either way.

Test Plan:
- W=H=8, K=3, S=1, avg, CHANNEL_NUM=1, pxl_in=row*8+col, continuous valid: 36 outputs; first = 9, three cycles after pixel (2,2) is sampled; last = 54; frame_done with output 36.
- W=H=8, K=2, S=2, max, same ramp: 16 outputs; first = 9, second = 11, last = 63.
- K=3 avg, all pixels -5: every output = -5. Then one window holding a single -14, rest 0: output -1 without POOL_ROUND_EN, -2 with it.
- Ramp from the first test with valid_in toggled 1,0,0,1,...: identical output values and count; each output exactly 3 cycles after its completing pixel.
- CHANNEL_NUM=3, plane p filled with constant p*10, K=3, avg: outputs 0 (x36), 10 (x36), 20 (x36); single frame_done on the final one.
- Assert reset low mid-plane 1 for 2 cycles, then restart: no valid_out during or after reset until a fresh full window arrives; first post-reset output matches the first test.
